serial_out_ctrl: RTL and testbench
==================================

# serial_out_ctrl

Serial transmitter for the board-level async serial link. Converts a parallel byte into a frame: one low start bit, 8 data bits LSB first, one high stop bit. It is the transmit-side companion of the serial input controller and runs at the same line rate: 50 MHz / 4096 ≈ 12207 baud. A one-entry holding register lets the producer queue the next byte while the current frame is on the line, giving back-to-back frames with no idle gap.

## Interface
- CLKS_PER_BIT, 4096, clock cycles per serial bit; legal range ≥ 2.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-low.
- parallel_data_in  in  8  byte to transmit; sampled only on an accepted load.
- load  in  1  load request; accepted on a rising edge where load=1 and ready=1.
- ready  out  1  holding register empty; a load is accepted this cycle.
- busy  out  1  frame in progress (state ≠ IDLE).
- char_sent  out  1  one-cycle pulse when a stop bit completes.
- ser_data_out  out  1  serial line; idles high.

## Operation
- Storage:
  - hold_reg[7:0] with hold_valid.
  - shift_reg[7:0].
  - bit_cnt[2:0] (data bit index).
  - baud_cnt, width $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1.
- ready = ~hold_valid. A load while ready=0 is ignored: data dropped, no state change.
- States:
  - IDLE: line = 1, baud_cnt held at 0. If hold_valid: go to START, shift_reg ← hold_reg, hold_valid ← 0.
  - START: line = 0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt = 0.
  - DATA: line = shift_reg[0]. At baud_cnt = CLKS_PER_BIT-1: shift right. If bit_cnt = 7 go to STOP, else bit_cnt+1.
  - STOP: line = 1 for CLKS_PER_BIT cycles. On the final cycle: char_sent ← 1 for one cycle. If hold_valid: go to START and transfer hold → shift (back-to-back). Otherwise go to IDLE.
- baud_cnt returns to 0 on every bit boundary and on every state change. It wraps at CLKS_PER_BIT-1, never at its power of two.
- Load and transfer in the same cycle:
  - A load accepted on the same edge as a STOP→START transfer cannot conflict, because a transfer requires hold_valid=1, which forces ready=0.
  - A load is accepted on the same edge that hold empties only if ready was already 1 before that edge. Otherwise it is accepted on the next cycle.
- ser_data_out is a register output (glitch-free).
- Reset (rst=0 at a rising edge), regardless of state, including mid-frame:
  - state IDLE; ser_data_out=1, busy=0, ready=1, char_sent=0.
  - hold_valid=0; all counters 0.
  - Any partial frame is aborted and the line returns high on that edge.

## Timing
- N = CLKS_PER_BIT. Edge 0 = the edge where a load is accepted from IDLE with hold empty.
- Edge 0: hold_valid=1, ready=0.
- Edge 1:
  - state START, ser_data_out=0, busy=1, ready=1.
  - Latency from load to the start-bit leading edge is 1 cycle.
- Edge 1+(i+1)·N, i=0..7: ser_data_out = data bit i.
- Edge 1+9·N: stop bit, ser_data_out=1.
- Edge 1+10·N, frame end:
  - char_sent=1 for exactly one cycle.
  - If idle next: busy=0 on the same edge.
  - Back-to-back: the next start bit begins on this same edge, busy stays 1, and ready rises.
- Frame length is exactly 10·N cycles. There are no idle cycles between back-to-back frames.

## Test plan
- Single byte, N=16, load 0xA5 at edge 0.
  - Line per 16-cycle bit from edge 1: 0,1,0,1,0,0,1,0,1,1.
  - char_sent pulses at edge 161; busy=0 at edge 161.
- Back-to-back, N=16: load 0x00, then 0xFF as soon as ready=1.
  - Frames are contiguous: the second start bit begins at edge 161.
  - char_sent pulses at 161 and 321. No high idle bit-time between frames.
- Load while full, N=16: load 0x3C, then 0x55 (accepted into hold), then 0xAA while ready=0.
  - Only 0x3C and 0x55 are transmitted.
  - 0xAA is dropped and two char_sent pulses occur.
- Reset mid-frame, N=16: load 0xF0, assert rst=0 at edge 50.
  - Edge 50: ser_data_out=1, busy=0, ready=1, no char_sent.
  - After release, load 0x81 → a clean frame 0,1,0,0,0,0,0,0,1,1.
- Default N=4096, byte 0x4B: each bit held exactly 4096 cycles; the whole frame is 40960 cycles.
- Idle hold: no load for 1000 cycles after reset → ser_data_out=1, busy=0, char_sent never asserted.

Source files
------------

// File: rtl/serial_out_ctrl_if.sv
// serial_out_ctrl_if: parallel load handshake and serial line of the transmitter
interface serial_out_ctrl_if;
    logic [7:0] parallel_data_in;
    logic       load;
    logic       ready;
    logic       busy;
    logic       char_sent;
    logic       ser_data_out;
    modport master (output parallel_data_in, load, input ready, busy, char_sent, ser_data_out);
    modport slave  (input parallel_data_in, load, output ready, busy, char_sent, ser_data_out);
endinterface

// File: rtl/serial_out_ctrl.sv
// serial_out_ctrl: 8N1 serial transmitter with a one-byte holding register for gapless frames
module serial_out_ctrl #(
    parameter int CLKS_PER_BIT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    serial_out_ctrl_if.slave  bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state;
    logic [7:0]    r_hold;
    logic          r_hold_valid;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [BW-1:0] r_baud;
    logic          r_ser;
    logic          r_busy;
    logic          r_char_sent;
    logic          w_accept;
    logic          w_bit_end;

    assign w_accept         = bus.load & ~r_hold_valid;
    assign w_bit_end        = r_baud == BAUD_MAX;
    assign bus.ready        = ~r_hold_valid;
    assign bus.busy         = r_busy;
    assign bus.char_sent    = r_char_sent;
    assign bus.ser_data_out = r_ser;

    // Frame FSM; the line level is registered together with the state it belongs to.
    // A load and a hold->shift transfer are mutually exclusive: transfer needs hold full, load needs it empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_baud       <= '0;
            r_ser        <= 1'b1;
            r_busy       <= 1'b0;
            r_char_sent  <= 1'b0;
        end else begin
            r_char_sent <= 1'b0;
            if (w_accept) begin
                r_hold       <= bus.parallel_data_in;
                r_hold_valid <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (r_hold_valid) begin
                        r_state      <= START;
                        r_shift      <= r_hold;
                        r_hold_valid <= 1'b0;
                        r_ser        <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                        r_ser     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                            r_ser   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_ser     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud      <= '0;
                        r_char_sent <= 1'b1;
                        if (r_hold_valid) begin
                            r_state      <= START;
                            r_shift      <= r_hold;
                            r_hold_valid <= 1'b0;
                            r_ser        <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_out_ctrl.sv
// tb_serial_out_ctrl: scoreboard bench for the serial transmitter at N=16 and at the default N=4096
module tb_serial_out_ctrl;
    localparam int NA = 16;
    localparam int NB = 4096;

    typedef struct {
        logic [9:0] frame;
        int         start;
        int         bad;
        int         early_cs;
        logic       cs_end;
        logic       busy_end;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];
    rec_t rx_q[$];
    logic mon_s [10*NA];

    serial_out_ctrl_if a();
    serial_out_ctrl_if b();

    serial_out_ctrl #(.CLKS_PER_BIT(NA)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    serial_out_ctrl dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the index of the rising edge just passed.
    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor for the N=16 instance: captures every cycle of each frame and records it.
    always begin
        @(negedge clk);
        while (rst === 1'b1 && a.ser_data_out === 1'b0) begin
            rec_t r;
            bit   ab;
            ab = 1'b0;
            r.start = cyc;
            r.early_cs = 0;
            mon_s[0] = a.ser_data_out;
            for (int c = 1; c < 10*NA; c++) begin
                @(negedge clk);
                if (rst !== 1'b1) begin
                    ab = 1'b1;
                    break;
                end
                mon_s[c] = a.ser_data_out;
                if (a.char_sent === 1'b1) r.early_cs++;
            end
            if (ab) break;
            @(negedge clk);
            r.cs_end = a.char_sent;
            r.busy_end = a.busy;
            r.bad = 0;
            for (int k = 0; k < 10; k++) begin
                r.frame[k] = mon_s[k*NA + NA/2];
                for (int j = 0; j < NA; j++)
                    if (mon_s[k*NA + j] !== r.frame[k]) r.bad++;
            end
            rx_q.push_back(r);
        end
    end

    task automatic drive_load(input bit sel, input logic [7:0] d, output bit acc, output int e);
        @(negedge clk);
        if (sel) begin
            b.load = 1'b1;
            b.parallel_data_in = d;
            acc = b.ready;
        end else begin
            a.load = 1'b1;
            a.parallel_data_in = d;
            acc = a.ready;
        end
        @(negedge clk);
        e = cyc;
        a.load = 1'b0;
        b.load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a.ser_data_out !== 1'b1) begin errors++; $display("FAIL reset_line got %b want 1", a.ser_data_out); end
        checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a.busy); end
        checks++; if (a.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", a.ready); end
        checks++; if (a.char_sent !== 1'b0) begin errors++; $display("FAIL reset_char_sent got %b want 0", a.char_sent); end
        rst = 1'b1;
    endtask

    task automatic test_idle();
        int bad_line, bad_busy, cs_seen;
        bad_line = 0; bad_busy = 0; cs_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (a.ser_data_out !== 1'b1) bad_line++;
            if (a.busy !== 1'b0) bad_busy++;
            if (a.char_sent !== 1'b0) cs_seen++;
        end
        checks++; if (bad_line != 0) begin errors++; $display("FAIL idle_line low_cycles %0d want 0", bad_line); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL idle_busy busy_cycles %0d want 0", bad_busy); end
        checks++; if (cs_seen != 0) begin errors++; $display("FAIL idle_char_sent pulses %0d want 0", cs_seen); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL idle_frames got %0d want 0", rx_q.size()); end
    endtask

    task automatic test_single();
        bit acc;
        int e0;
        rec_t r;
        logic [7:0] d;
        drive_load(1'b0, 8'hA5, acc, e0);
        exp_q.push_back(8'hA5);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", acc); end
        checks++; if (a.ready !== 1'b0) begin errors++; $display("FAIL single_ready_e0 got %b want 0", a.ready); end
        @(negedge clk);
        checks++; if (a.ser_data_out !== 1'b0 || a.busy !== 1'b1 || a.ready !== 1'b1)
            begin errors++; $display("FAIL single_e1 line/busy/ready got %b%b%b want 011", a.ser_data_out, a.busy, a.ready); end
        for (int t = 0; t < 400 && rx_q.size() < 1; t++) @(negedge clk);
        checks++;
        if (rx_q.size() < 1) begin
            errors++; $display("FAIL single_timeout frames %0d want 1", rx_q.size());
        end else begin
            r = rx_q.pop_front();
            d = exp_q.pop_front();
            checks++; if (r.frame !== {1'b1, d, 1'b0}) begin errors++; $display("FAIL single_frame got %b want %b", r.frame, {1'b1, d, 1'b0}); end
            checks++; if (r.start != e0 + 1) begin errors++; $display("FAIL single_start got %0d want %0d", r.start, e0 + 1); end
            checks++; if (r.bad != 0) begin errors++; $display("FAIL single_bit_width bad_cycles %0d want 0", r.bad); end
            checks++; if (r.early_cs != 0) begin errors++; $display("FAIL single_early_cs got %0d want 0", r.early_cs); end
            checks++; if (r.cs_end !== 1'b1) begin errors++; $display("FAIL single_cs_end got %b want 1", r.cs_end); end
            checks++; if (r.busy_end !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", r.busy_end); end
            @(negedge clk);
            checks++; if (a.char_sent !== 1'b0) begin errors++; $display("FAIL single_cs_width got %b want 0", a.char_sent); end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int e0, e1;
        rec_t r1, r2;
        logic [7:0] d1, d2;
        drive_load(1'b0, 8'h00, acc, e0);
        exp_q.push_back(8'h00);
        for (int t = 0; t < 100 && a.ready !== 1'b1; t++) @(negedge clk);
        drive_load(1'b0, 8'hFF, acc, e1);
        exp_q.push_back(8'hFF);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept2 got %b want 1", acc); end
        for (int t = 0; t < 500 && rx_q.size() < 2; t++) @(negedge clk);
        checks++;
        if (rx_q.size() < 2) begin
            errors++; $display("FAIL b2b_timeout frames %0d want 2", rx_q.size());
        end else begin
            r1 = rx_q.pop_front(); r2 = rx_q.pop_front();
            d1 = exp_q.pop_front(); d2 = exp_q.pop_front();
            checks++; if (r1.frame !== {1'b1, d1, 1'b0}) begin errors++; $display("FAIL b2b_frame1 got %b want %b", r1.frame, {1'b1, d1, 1'b0}); end
            checks++; if (r2.frame !== {1'b1, d2, 1'b0}) begin errors++; $display("FAIL b2b_frame2 got %b want %b", r2.frame, {1'b1, d2, 1'b0}); end
            checks++; if (r1.start != e0 + 1) begin errors++; $display("FAIL b2b_start1 got %0d want %0d", r1.start, e0 + 1); end
            checks++; if (r2.start != e0 + 1 + 10*NA) begin errors++; $display("FAIL b2b_start2 got %0d want %0d", r2.start, e0 + 1 + 10*NA); end
            checks++; if (r1.cs_end !== 1'b1 || r2.cs_end !== 1'b1) begin errors++; $display("FAIL b2b_cs got %b%b want 11", r1.cs_end, r2.cs_end); end
            checks++; if (r1.busy_end !== 1'b1) begin errors++; $display("FAIL b2b_busy_gap got %b want 1", r1.busy_end); end
            checks++; if (r2.busy_end !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", r2.busy_end); end
            checks++; if (r1.bad + r2.bad != 0) begin errors++; $display("FAIL b2b_bit_width bad_cycles %0d want 0", r1.bad + r2.bad); end
        end
    endtask

    task automatic test_load_full();
        bit acc;
        int e;
        rec_t r;
        logic [7:0] d;
        drive_load(1'b0, 8'h3C, acc, e);
        exp_q.push_back(8'h3C);
        for (int t = 0; t < 100 && a.ready !== 1'b1; t++) @(negedge clk);
        drive_load(1'b0, 8'h55, acc, e);
        exp_q.push_back(8'h55);
        drive_load(1'b0, 8'hAA, acc, e);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL full_ready_while_full got %b want 0", acc); end
        for (int t = 0; t < 500 && rx_q.size() < 2; t++) @(negedge clk);
        checks++;
        if (rx_q.size() < 2) begin
            errors++; $display("FAIL full_timeout frames %0d want 2", rx_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                r = rx_q.pop_front();
                d = exp_q.pop_front();
                checks++; if (r.frame !== {1'b1, d, 1'b0}) begin errors++; $display("FAIL full_frame%0d got %b want %b", k, r.frame, {1'b1, d, 1'b0}); end
            end
            repeat (200) @(negedge clk);
            checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL full_dropped extra_frames %0d want 0", rx_q.size()); end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int e0;
        rec_t r;
        logic [7:0] d;
        drive_load(1'b0, 8'hF0, acc, e0);
        for (int t = 0; t < 100 && cyc < e0 + 49; t++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cyc != e0 + 50) begin errors++; $display("FAIL rmid_edge got %0d want %0d", cyc, e0 + 50); end
        checks++; if (a.ser_data_out !== 1'b1 || a.busy !== 1'b0 || a.ready !== 1'b1 || a.char_sent !== 1'b0)
            begin errors++; $display("FAIL rmid_state line/busy/ready/cs got %b%b%b%b want 1010", a.ser_data_out, a.busy, a.ready, a.char_sent); end
        @(negedge clk);
        rst = 1'b1;
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rmid_aborted frames %0d want 0", rx_q.size()); end
        drive_load(1'b0, 8'h81, acc, e0);
        exp_q.push_back(8'h81);
        for (int t = 0; t < 400 && rx_q.size() < 1; t++) @(negedge clk);
        checks++;
        if (rx_q.size() < 1) begin
            errors++; $display("FAIL rmid_timeout frames %0d want 1", rx_q.size());
        end else begin
            r = rx_q.pop_front();
            d = exp_q.pop_front();
            checks++; if (r.frame !== {1'b1, d, 1'b0}) begin errors++; $display("FAIL rmid_frame got %b want %b", r.frame, {1'b1, d, 1'b0}); end
            checks++; if (r.bad != 0 || r.cs_end !== 1'b1) begin errors++; $display("FAIL rmid_clean bad %0d cs %b want 0 1", r.bad, r.cs_end); end
        end
    endtask

    task automatic test_default();
        bit acc;
        int e0, mism, early;
        logic [9:0] exp_f;
        exp_f = {1'b1, 8'h4B, 1'b0};
        early = 0;
        drive_load(1'b1, 8'h4B, acc, e0);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL def_accept got %b want 1", acc); end
        for (int i = 0; i < 10; i++) begin
            mism = 0;
            for (int k = 0; k < NB; k++) begin
                @(negedge clk);
                if (b.ser_data_out !== exp_f[i]) mism++;
                if (b.char_sent === 1'b1) early++;
            end
            checks++; if (mism != 0) begin errors++; $display("FAIL def_bit%0d wrong_cycles %0d want 0", i, mism); end
        end
        @(negedge clk);
        checks++; if (b.char_sent !== 1'b1 || b.busy !== 1'b0) begin errors++; $display("FAIL def_end cs/busy got %b%b want 10", b.char_sent, b.busy); end
        checks++; if (early != 0) begin errors++; $display("FAIL def_early_cs got %0d want 0", early); end
        @(negedge clk);
        checks++; if (b.char_sent !== 1'b0) begin errors++; $display("FAIL def_cs_width got %b want 0", b.char_sent); end
    endtask

    // Test sequence.
    initial begin
        a.load = 1'b0; a.parallel_data_in = '0;
        b.load = 1'b0; b.parallel_data_in = '0;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_load_full();
        test_reset_mid();
        test_default();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
